// File: rtl/key_ctrl.sv
// key_ctrl -- front-panel key conditioner feeding the LED blink stage.
//
// Synchronises one raw active-low push-button into sys_clk, debounces it,
// classifies each press as short or long, and maintains the two control
// values consumed by the blinker: a blink-rate select stepped by short
// presses and an LED enable toggled by long presses.
//
// Parameters
//   DEBOUNCE_CYC  stable-input cycles before the debounced level changes
//   LONG_CYC      cycles of debounced hold before a press counts as long
//
// Ports
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   key_n        in   raw button, asynchronous, 0 = pressed
//   key_level    out  debounced level, 1 = pressed
//   short_press  out  one-cycle pulse on release of a short press
//   long_press   out  one-cycle pulse when a hold reaches LONG_CYC
//   rate_sel     out  blink-rate select, steps modulo 4 on short presses
//   led_en       out  LED enable, toggles on long presses (1 after reset)
module key_ctrl #(
  parameter int DEBOUNCE_CYC = 540000,
  parameter int LONG_CYC     = 27000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_n,
  output logic       key_level,
  output logic       short_press,
  output logic       long_press,
  output logic [1:0] rate_sel,
  output logic       led_en
);

  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HOLD_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_t;

  // Two-flop synchroniser; both flops rest at 1 (released) out of reset.
  logic sync1_q, sync2_q;
  logic s;

  // Debounce state
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q,  level_d;

  // Press FSM state and registered outputs
  state_t            state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              short_q, long_q;
  logic [1:0]        rate_q;
  logic              led_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  // Any disagreement must persist for DEBOUNCE_CYC consecutive cycles; a
  // single sample agreeing with the current level restarts the count.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (s != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = s;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
    end
  end

  // Press classification. Release is tested before the long threshold so a
  // release landing on the last hold cycle is still a short press. The hold
  // counter stops at LONG_CYC-1 and therefore never wraps.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      rate_q     <= 2'd0;
      led_q      <= 1'b1;
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (level_q) begin
            state_q    <= PRESSED;
            hold_cnt_q <= '0;
          end
        end
        PRESSED: begin
          if (!level_q) begin
            short_q <= 1'b1;
            rate_q  <= rate_q + 2'd1;
            state_q <= IDLE;
          end else if (hold_cnt_q == HOLD_LAST) begin
            long_q  <= 1'b1;
            led_q   <= ~led_q;
            state_q <= LONG;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        LONG: begin
          if (!level_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_level   = level_q;
  assign short_press = short_q;
  assign long_press  = long_q;
  assign rate_sel    = rate_q;
  assign led_en      = led_q;

endmodule

// File: tb/tb_key_ctrl.sv
// tb_key_ctrl -- directed table-driven bench for key_ctrl with
// DEBOUNCE_CYC=8 and LONG_CYC=50. Inputs change on the falling clock edge
// and outputs are sampled on the falling edge, half a cycle after the
// rising edge that updated them.
module tb_key_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_n;
  logic       key_level;
  logic       short_press;
  logic       long_press;
  logic [1:0] rate_sel;
  logic       led_en;

  key_ctrl #(
    .DEBOUNCE_CYC(8),
    .LONG_CYC    (50)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .short_press(short_press),
    .long_press (long_press),
    .rate_sel   (rate_sel),
    .led_en     (led_en)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Observations collected by seg(); indices count rising edges since the
  // start of the current press (first edge sampling the new key_n is 1).
  int idx, rise_idx, sp_idx, lp_idx, n_sp, n_lp, n_both, any_level;

  typedef struct {
    int low;
    int exp_rise;
    int exp_sp_idx;
    int exp_lp_idx;
    int exp_nsp;
    int exp_nlp;
    int exp_rate;
    int exp_led;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string nm, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    idx = 0; rise_idx = 0; sp_idx = 0; lp_idx = 0;
    n_sp = 0; n_lp = 0; n_both = 0; any_level = 0;
  endtask

  task automatic seg(input logic v, input int n);
    key_n = v;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      idx++;
      if (key_level) begin
        any_level = 1;
        if (rise_idx == 0) rise_idx = idx;
      end
      if (short_press) begin
        n_sp++;
        if (sp_idx == 0) sp_idx = idx;
      end
      if (long_press) begin
        n_lp++;
        if (lp_idx == 0) lp_idx = idx;
      end
      if (short_press && long_press) n_both++;
    end
  endtask

  initial begin
    int held;

    tbl[0] = '{30,  10, 41, 0,  1, 0, 1, 1};
    tbl[1] = '{30,  10, 41, 0,  1, 0, 2, 1};
    tbl[2] = '{30,  10, 41, 0,  1, 0, 3, 1};
    tbl[3] = '{30,  10, 41, 0,  1, 0, 0, 1};
    tbl[4] = '{100, 10, 0,  61, 0, 1, 0, 0};
    tbl[5] = '{100, 10, 0,  61, 0, 1, 0, 1};
    tbl[6] = '{50,  10, 61, 0,  1, 0, 1, 1};
    tbl[7] = '{51,  10, 0,  61, 0, 1, 1, 0};
    tbl[8] = '{7,   0,  0,  0,  0, 0, 1, 0};
    tbl[9] = '{10,  10, 21, 0,  1, 0, 2, 0};

    // Reset held with the key pressed: everything stays at reset values.
    sys_rst_n = 1'b0;
    key_n     = 1'b0;
    held      = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      if (key_level !== 1'b0 || short_press !== 1'b0 || long_press !== 1'b0 ||
          rate_sel !== 2'd0 || led_en !== 1'b1) held = 0;
    end
    check("reset key_level", int'(key_level), 0);
    check("reset short_press", int'(short_press), 0);
    check("reset long_press", int'(long_press), 0);
    check("reset rate_sel", int'(rate_sel), 0);
    check("reset led_en", int'(led_en), 1);
    check("reset held", held, 1);

    key_n     = 1'b1;
    sys_rst_n = 1'b1;
    clr();
    seg(1'b1, 10);

    // Bounce: no low run long enough to change the debounced level.
    clr();
    seg(1'b0, 5);
    seg(1'b1, 3);
    seg(1'b0, 5);
    seg(1'b1, 20);
    check("bounce key_level", any_level, 0);
    check("bounce short", n_sp, 0);
    check("bounce long", n_lp, 0);
    check("bounce rate_sel", int'(rate_sel), 0);

    for (int r = 0; r < 10; r++) begin
      clr();
      seg(1'b0, tbl[r].low);
      seg(1'b1, 20);
      check($sformatf("row%0d rise_edge", r), rise_idx, tbl[r].exp_rise);
      check($sformatf("row%0d short_edge", r), sp_idx, tbl[r].exp_sp_idx);
      check($sformatf("row%0d long_edge", r), lp_idx, tbl[r].exp_lp_idx);
      check($sformatf("row%0d short_count", r), n_sp, tbl[r].exp_nsp);
      check($sformatf("row%0d long_count", r), n_lp, tbl[r].exp_nlp);
      check($sformatf("row%0d both_high", r), n_both, 0);
      check($sformatf("row%0d rate_sel", r), int'(rate_sel), tbl[r].exp_rate);
      check($sformatf("row%0d led_en", r), int'(led_en), tbl[r].exp_led);
    end

    // Reset while PRESSED with rate_sel=2, led_en=0 beforehand.
    clr();
    seg(1'b0, 30);
    check("midrst pre rise", rise_idx, 10);
    check("midrst pre pulses", n_sp + n_lp, 0);
    sys_rst_n = 1'b0;
    #1;
    check("midrst key_level", int'(key_level), 0);
    check("midrst rate_sel", int'(rate_sel), 0);
    check("midrst led_en", int'(led_en), 1);
    check("midrst pulses", int'(short_press) + int'(long_press), 0);
    clr();
    seg(1'b0, 3);
    check("midrst held level", any_level, 0);
    check("midrst held pulses", n_sp + n_lp, 0);
    sys_rst_n = 1'b1;
    clr();
    seg(1'b0, 30);
    check("post rst rise_edge", rise_idx, 10);
    check("post rst no pulse", n_sp + n_lp, 0);
    check("post rst rate_sel", int'(rate_sel), 0);
    check("post rst led_en", int'(led_en), 1);
    seg(1'b1, 20);
    check("post rst short_edge", sp_idx, 41);
    check("post rst short_count", n_sp, 1);
    check("post rst long_count", n_lp, 0);
    check("post rst rate_sel final", int'(rate_sel), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
